// File: rtl/cpu_sram_arbiter.sv
// Arbitrates the CPU instruction and data requesters onto a single SRAM-like port.
// Data wins ties unless inst has been passed over STARVE_LIMIT times in a row.
module cpu_sram_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       gnt_data;
   logic [7:0] streak;
   logic       any_req;
   logic       sel_data;
   logic       accept;

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

   always_comb begin
      any_req      = inst_req | data_req;
      // Inst only overrides a pending data request once it has been starved long enough.
      sel_data     = data_req & ~(inst_req & (LIMIT != 8'd0) & (streak >= LIMIT));
      accept       = resetn & (state_q == IDLE) & any_req;
      state_d      = state_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d      = REQ;
               inst_addr_ok = ~sel_data;
               data_addr_ok = sel_data;
            end
         end
         REQ: begin
            if (mem_addr_ok) state_d = RESP;
         end
         RESP: begin
            inst_data_ok = mem_data_ok & ~gnt_data;
            data_data_ok = mem_data_ok & gnt_data;
            if (mem_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!resetn) begin
         inst_addr_ok = 1'b0;
         data_addr_ok = 1'b0;
         inst_data_ok = 1'b0;
         data_data_ok = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_size  <= 2'd0;
         mem_addr  <= 32'd0;
         mem_wstrb <= 4'd0;
         mem_wdata <= 32'd0;
         gnt_data  <= 1'b0;
         streak    <= 8'd0;
      end else if (accept) begin
         mem_req  <= 1'b1;
         gnt_data <= sel_data;
         if (sel_data) begin
            mem_wr    <= data_wr;
            mem_size  <= data_size;
            mem_addr  <= data_addr;
            mem_wstrb <= data_wstrb;
            mem_wdata <= data_wdata;
         end else begin
            mem_wr    <= inst_wr;
            mem_size  <= inst_size;
            mem_addr  <= inst_addr;
            mem_wstrb <= inst_wstrb;
            mem_wdata <= inst_wdata;
         end
         // Streak counts only data wins that actually made inst wait.
         if (sel_data && inst_req) streak <= (streak == 8'hFF) ? streak : streak + 8'd1;
         else                      streak <= 8'd0;
      end else if ((state_q == REQ) && mem_addr_ok) begin
         mem_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

  localparam int SL = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } fields_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic [3:0]  inst_wstrb = '0;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        p_inst_addr_ok, p_inst_data_ok, p_data_addr_ok, p_data_data_ok;
  logic [31:0] p_inst_rdata, p_data_rdata;
  logic        p_mem_req, p_mem_wr;
  logic [1:0]  p_mem_size;
  logic [31:0] p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_wstrb;

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  cpu_sram_arbiter #(.STARVE_LIMIT(0)) u_pure (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(p_inst_addr_ok), .inst_data_ok(p_inst_data_ok), .inst_rdata(p_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(p_data_addr_ok), .data_data_ok(p_data_data_ok), .data_rdata(p_data_rdata),
    .mem_req(p_mem_req), .mem_wr(p_mem_wr), .mem_size(p_mem_size), .mem_addr(p_mem_addr),
    .mem_wstrb(p_mem_wstrb), .mem_wdata(p_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int      n_assert = 0;
  int      n_fail = 0;
  bit      m_open = 0, m_acc = 0, m_owner_data = 0;
  fields_t m_f = '0;
  int      m_streak = 0;
  bit      acc_inst = 0, acc_data = 0;
  bit      chk_pure = 0;
  int      glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner();
    if (!inst_req && !data_req) return 0;
    if (inst_req && !data_req)  return 1;
    if (data_req && !inst_req)  return 2;
    if (SL != 0 && m_streak >= SL) return 1;
    return 2;
  endfunction

  task automatic check();
    int w;
    #1;
    w = (m_open || !resetn) ? 0 : m_winner();
    chk("inst_addr_ok", inst_addr_ok, (w == 1));
    chk("data_addr_ok", data_addr_ok, (w == 2));
    chk("mem_req", mem_req, (m_open && !m_acc));
    chk("inst_data_ok", inst_data_ok, (resetn && m_open && m_acc && mem_data_ok && !m_owner_data));
    chk("data_data_ok", data_data_ok, (resetn && m_open && m_acc && mem_data_ok && m_owner_data));
    chk("mem_wr", mem_wr, m_f.wr);
    chk("mem_size", mem_size, m_f.size);
    chk("mem_addr", mem_addr, m_f.addr);
    chk("mem_wstrb", mem_wstrb, m_f.wstrb);
    chk("mem_wdata", mem_wdata, m_f.wdata);
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    if (inst_addr_ok) glog.push_back(1);
    if (data_addr_ok) glog.push_back(2);
    if (chk_pure) begin
      chk("pure_inst_addr_ok", p_inst_addr_ok, 1'b0);
      chk("pure_data_addr_ok", p_data_addr_ok, (inst_addr_ok | data_addr_ok));
      chk("pure_mem_req", p_mem_req, mem_req);
    end
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    w = m_winner();
    acc_inst = 0;
    acc_data = 0;
    if (!resetn) begin
      m_open = 0; m_acc = 0; m_owner_data = 0; m_f = '0; m_streak = 0;
    end else if (!m_open) begin
      if (w != 0) begin
        m_open = 1;
        m_acc = 0;
        m_owner_data = (w == 2);
        if (w == 2) m_f = '{data_wr, data_size, data_addr, data_wstrb, data_wdata};
        else        m_f = '{inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
        if (w == 2 && inst_req) m_streak = (m_streak < 255) ? m_streak + 1 : 255;
        else                    m_streak = 0;
        acc_inst = (w == 1);
        acc_data = (w == 2);
      end
    end else if (!m_acc) begin
      if (mem_addr_ok) m_acc = 1;
    end else if (mem_data_ok) begin
      m_open = 0;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    check();
    advance();
  endtask

  task automatic do_reset();
    resetn = 0;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    cyc();
    cyc();
    resetn = 1;
  endtask

  initial begin
    int pulses;
    int exp_order[6] = '{2, 2, 1, 2, 2, 1};
    @(negedge clk);

    do_reset();
    check();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    advance();

    inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1C00_0000;
    check();
    chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    advance();
    inst_req = 0;
    check();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
    advance();
    mem_addr_ok = 1;
    cyc();
    mem_addr_ok = 0;
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    check();
    chk("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("t1_data_data_ok", data_data_ok, 1'b0);
    advance();
    mem_data_ok = 0;
    cyc();

    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h0000_1004;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    check();
    chk("t2_data_addr_ok", data_addr_ok, 1'b1);
    advance();
    data_req = 0; data_wdata = 32'h0; data_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_addr_ok = (i == 3);
      check();
      chk("t2_mem_req", mem_req, 1'b1);
      chk("t2_mem_addr", mem_addr, 32'h0000_1004);
      chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      advance();
    end
    mem_addr_ok = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      mem_data_ok = (i != 0);
      check();
      if (data_data_ok) pulses++;
      chk("t2_inst_data_ok", inst_data_ok, 1'b0);
      advance();
    end
    chk("t2_pulses", pulses, 1);
    mem_data_ok = 0;

    do_reset();
    glog.delete();
    chk_pure = 1;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1C00_0040;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_2000;
    mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 40 && glog.size() < 6; i++) cyc();
    chk("t3_grant_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      int g;
      g = (i < glog.size()) ? glog[i] : 0;
      chk("t3_grant_order", g, exp_order[i]);
    end
    chk_pure = 0;

    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0080;
    cyc();
    inst_req = 0; mem_addr_ok = 1;
    cyc();
    mem_addr_ok = 0;
    cyc();
    resetn = 0;
    cyc();
    resetn = 1;
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    check();
    chk("t4_inst_data_ok", inst_data_ok, 1'b0);
    chk("t4_data_data_ok", data_data_ok, 1'b0);
    advance();
    mem_data_ok = 0;
    inst_req = 1; inst_addr = 32'h1C00_0100;
    check();
    chk("t4_inst_addr_ok", inst_addr_ok, 1'b1);
    advance();
    inst_req = 0;
    check();
    chk("t4_mem_addr", mem_addr, 32'h1C00_0100);
    advance();
    mem_addr_ok = 1;
    cyc();
    mem_addr_ok = 0; mem_data_ok = 1;
    cyc();
    mem_data_ok = 0;

    for (int i = 0; i < 3; i++) begin
      mem_data_ok = 1;
      check();
      chk("t5_inst_data_ok", inst_data_ok, 1'b0);
      chk("t5_data_data_ok", data_data_ok, 1'b0);
      chk("t5_mem_req", mem_req, 1'b0);
      advance();
    end
    mem_data_ok = 0;

    for (int c = 0; c < 3000; c++) begin
      if (!inst_req && $urandom_range(3) == 0) begin
        inst_req   = 1;
        inst_wr    = ($urandom_range(7) == 0);
        inst_size  = 2'($urandom_range(2));
        inst_addr  = $urandom;
        inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
      end
      if (!data_req && $urandom_range(2) == 0) begin
        data_req   = 1;
        data_wr    = 1'($urandom_range(1));
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(2) != 0);
      mem_data_ok = ($urandom_range(2) == 0);
      mem_rdata   = $urandom;
      resetn      = ($urandom_range(199) != 0);
      cyc();
      if (acc_inst) inst_req = 0;
      if (acc_data) data_req = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction requester (IF stage) and data requester (EXE/MEM stages).
- Each requester port uses the req/addr_ok/data_ok handshake. Data has fixed priority over inst, with an optional anti-starvation limit for inst.
- Only one transaction is outstanding at a time.
- Sits between mycpu_top's two request ports and the single memory/bridge port.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while inst_req is pending before inst is forced to win. 0 = pure data priority. Legal range 0..255.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  inst request valid
- inst_wr  in  1  inst write flag (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  inst address
- inst_wstrb  in  4  inst byte strobes
- inst_wdata  in  32  inst write data
- inst_addr_ok  out  1  inst request accepted this cycle
- inst_data_ok  out  1  inst response valid this cycle
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data request, same meaning as inst_*
- data_addr_ok, data_data_ok  out  1/1  data handshake
- data_rdata  out  32  data read data
- mem_req  out  1  memory request valid (registered)
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  latched request fields (registered)
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, REQ, RESP. Registered grant flag gnt_data (1=data, 0=inst). 8-bit streak counter.
- IDLE:
  - Winner selection:
    - data_req & !inst_req → data.
    - inst_req & !data_req → inst.
    - Both pending → inst if STARVE_LIMIT!=0 and streak>=STARVE_LIMIT, else data.
  - addr_ok is asserted combinationally to the winner only; the loser sees addr_ok=0.
  - On the accept edge: latch winner's wr/size/addr/wstrb/wdata into mem_* and set gnt_data.
  - Set mem_req=1 and go to REQ.
  - No request → stay in IDLE.
- REQ:
  - mem_req=1. mem_* fields stay stable until mem_addr_ok.
  - mem_addr_ok=1 → mem_req<=0, go to RESP.
  - Requesters see addr_ok=0 throughout REQ.
- RESP:
  - Wait for mem_data_ok.
  - Granted side's data_ok = mem_data_ok; the other side's data_ok = 0.
  - inst_rdata and data_rdata both pass mem_rdata through combinationally. Requesters qualify it with their own data_ok.
  - On mem_data_ok → IDLE.
  - Writes also complete with mem_data_ok.
- mem_data_ok in IDLE or REQ is ignored: no data_ok is forwarded and state is unchanged.
- Minimum turnaround is 3 cycles per transaction (accept, mem accept, response). The next acceptance can occur in the cycle after the response.
- Streak counter, updated only on an IDLE accept:
  - Data wins with inst_req=1 → increment, saturating at 255.
  - Data wins with inst_req=0 → clear.
  - Inst wins → clear.
- Reset (resetn=0 at a clock edge), regardless of state:
  - state=IDLE, mem_req=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, gnt_data=0, streak=0.
  - All addr_ok/data_ok outputs are 0 while resetn=0.
  - A transaction in flight at reset is abandoned. A late mem_data_ok after reset lands in IDLE and is dropped.
- Requester obligation: hold req and its fields stable until addr_ok. The arbiter does not buffer unaccepted requests.

Test Plan:
- Single inst read: inst_req=1, addr=0x1C000000; mem_addr_ok 1 cycle after mem_req; mem_data_ok 2 cycles later with rdata=0x02800C0C → inst_addr_ok in cycle 0; mem_req high cycle 1 with mem_addr=0x1C000000, mem_wr=0; inst_data_ok=1 with inst_rdata=0x02800C0C; data_data_ok stays 0.
- Data write: data_req=1, wr=1, addr=0x0000_1004, wstrb=0xF, wdata=0xDEADBEEF, mem_addr_ok held low 3 cycles → mem_* stable across all 4 REQ cycles; data_data_ok pulses once on mem_data_ok.
- Simultaneous requests, STARVE_LIMIT=0, both held for 3 transactions → data granted all 3 times; inst_addr_ok never asserted.
- Starvation, STARVE_LIMIT=2, both requesting continuously → grant order data, data, inst, data, data, inst.
- Reset in RESP: resetn=0 one cycle while waiting; mem_data_ok arrives 2 cycles after release → no data_ok to either side; the next inst_req is accepted normally with mem_addr=the new address.
- Spurious mem_data_ok in IDLE with no requests → all data_ok remain 0 and mem_req remains 0.
